// File: rtl/jspcpu_pkg.sv
// Shared CPU definitions: FSM state encodings, bridge opcodes and
// default bus widths for the memory-side peripherals.
package jspcpu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_ACCESS  = 3'd2,
        ST_RECOVER = 3'd3,
        ST_HOLD    = 3'd4
    } state_e;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_e;

    localparam int DEF_WIDTH_ADDR = 16;
    localparam int DEF_WIDTH_MAIN = 8;
    localparam int WAIT_W         = 4;

endpackage

// File: rtl/mem_bridge_if.sv
// CPU-side request bus and SRAM pin bundle for the memory bridge.
// The bridge is the slave; the CPU/SRAM environment is the master.
interface mem_bridge_if import jspcpu_pkg::*; #(
    parameter int WIDTH_ADDR = DEF_WIDTH_ADDR,
    parameter int WIDTH_MAIN = DEF_WIDTH_MAIN
);
    logic [WIDTH_ADDR-1:0] addr_in;
    logic                  addr_valid;
    logic [WIDTH_MAIN-1:0] main_in;
    logic                  read_mem;
    logic                  write_mem;
    logic [WIDTH_MAIN-1:0] main_out;
    logic                  main_en;
    logic                  ready;
    logic [WIDTH_ADDR-1:0] sram_addr;
    logic [WIDTH_MAIN-1:0] sram_dq_out;
    logic [WIDTH_MAIN-1:0] sram_dq_in;
    logic                  sram_dq_oe;
    logic                  sram_ce_n;
    logic                  sram_oe_n;
    logic                  sram_we_n;

    modport slave (
        input  addr_in, addr_valid, main_in,
        input  read_mem, write_mem, sram_dq_in,
        output main_out, main_en, ready,
        output sram_addr, sram_dq_out, sram_dq_oe,
        output sram_ce_n, sram_oe_n, sram_we_n
    );

    modport master (
        output addr_in, addr_valid, main_in,
        output read_mem, write_mem, sram_dq_in,
        input  main_out, main_en, ready,
        input  sram_addr, sram_dq_out, sram_dq_oe,
        input  sram_ce_n, sram_oe_n, sram_we_n
    );

endinterface

// File: rtl/mem_bridge_wait_counter.sv
// Loadable 4-bit down-counter with zero flag, shared by the
// wait-stated peripherals. Decrement saturates at zero.
module wait_counter import jspcpu_pkg::*; (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic [WAIT_W-1:0] load_val_i,
    input  logic              dec_i,
    output logic              zero_o
);
    logic [WAIT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = load_val_i;
        else if (dec_i && cnt_q != '0)
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mem_bridge.sv
// Wait-stated bridge from the CPU address/main buses to an async SRAM.
// All SRAM strobes and bus outputs are registered straight off the FSM.
module mem_bridge import jspcpu_pkg::*; #(
    parameter int WIDTH_ADDR  = DEF_WIDTH_ADDR,
    parameter int WIDTH_MAIN  = DEF_WIDTH_MAIN,
    parameter int WAIT_STATES = 2
) (
    input  logic         clk,
    input  logic         reset,
    mem_bridge_if.slave  bus
);
    localparam logic [WAIT_W-1:0] WS_LD = WAIT_W'(WAIT_STATES);

    state_e                state_q;
    op_e                   op_q;
    logic [WIDTH_ADDR-1:0] addr_q;
    logic [WIDTH_MAIN-1:0] dout_q;
    logic [WIDTH_MAIN-1:0] mout_q;
    logic                  men_q;
    logic                  rdy_q;
    logic                  ce_n_q;
    logic                  oe_n_q;
    logic                  we_n_q;
    logic                  dq_oe_q;

    logic cnt_load, cnt_dec, cnt_zero;

    assign cnt_load = (state_q == ST_SETUP);
    assign cnt_dec  = (state_q == ST_ACCESS);

    wait_counter u_wait (
        .clk        (clk),
        .rst        (reset),
        .load_i     (cnt_load),
        .load_val_i (WS_LD),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            op_q    <= OP_READ;
            addr_q  <= '0;
            dout_q  <= '0;
            mout_q  <= '0;
            men_q   <= 1'b0;
            rdy_q   <= 1'b1;
            ce_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            dq_oe_q <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    // both strobes low is illegal and falls through
                    if (bus.addr_valid && (bus.read_mem ^ bus.write_mem)) begin
                        addr_q  <= bus.addr_in;
                        state_q <= ST_SETUP;
                        rdy_q   <= 1'b0;
                        ce_n_q  <= 1'b0;
                        if (!bus.write_mem) begin
                            op_q    <= OP_WRITE;
                            dout_q  <= bus.main_in;
                            dq_oe_q <= 1'b1;
                        end else begin
                            op_q   <= OP_READ;
                            oe_n_q <= 1'b0;
                        end
                    end
                end
                ST_SETUP: begin
                    state_q <= ST_ACCESS;
                    if (op_q == OP_WRITE)
                        we_n_q <= 1'b0;
                end
                ST_ACCESS: begin
                    if (cnt_zero) begin
                        if (op_q == OP_WRITE) begin
                            we_n_q  <= 1'b1;
                            state_q <= ST_RECOVER;
                        end else begin
                            mout_q  <= bus.sram_dq_in;
                            men_q   <= ~bus.read_mem;
                            rdy_q   <= 1'b1;
                            ce_n_q  <= 1'b1;
                            oe_n_q  <= 1'b1;
                            state_q <= ST_HOLD;
                        end
                    end
                end
                ST_RECOVER: begin
                    ce_n_q  <= 1'b1;
                    dq_oe_q <= 1'b0;
                    rdy_q   <= 1'b1;
                    state_q <= ST_IDLE;
                end
                ST_HOLD: begin
                    men_q <= ~bus.read_mem;
                    if (bus.read_mem)
                        state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.main_out    = mout_q;
    assign bus.main_en     = men_q;
    assign bus.ready       = rdy_q;
    assign bus.sram_addr   = addr_q;
    assign bus.sram_dq_out = dout_q;
    assign bus.sram_dq_oe  = dq_oe_q;
    assign bus.sram_ce_n   = ce_n_q;
    assign bus.sram_oe_n   = oe_n_q;
    assign bus.sram_we_n   = we_n_q;

endmodule

// File: doc/mem_bridge.md
Name: mem_bridge

Overview:
- Downstream consumer of the address bus and bidirectional partner on the main bus.
- Takes the 16-bit address driven by the xfer/address registers plus an active-low read or write strobe from the control unit.
- Runs a multi-cycle, wait-stated access to an external asynchronous SRAM.
- Holds read data for the main bus; raises `ready` to un-stall the sequencer.

Parameters:
- WIDTH_ADDR, 16, address bus width in bits.
- WIDTH_MAIN, 8, main/data bus width in bits.
- WAIT_STATES, 2, extra ACCESS cycles beyond one (legal 0..15).

Ports:
- clk  in  1  system clock; all state changes on posedge.
- reset  in  1  asynchronous, active-high reset.
- addr_in  in  WIDTH_ADDR  address bus value.
- addr_valid  in  1  address bus enable, active-high (from the driving register's addr_en).
- main_in  in  WIDTH_MAIN  main bus value (write data).
- read_mem  in  1  active-low: read SRAM, assert result on main bus.
- write_mem  in  1  active-low: write main bus value to SRAM.
- main_out  out  WIDTH_MAIN  read data register.
- main_en  out  1  active-high main bus drive enable.
- ready  out  1  high when no access is in flight; low means stall.
- sram_addr  out  WIDTH_ADDR  latched address.
- sram_dq_out  out  WIDTH_MAIN  latched write data.
- sram_dq_in  in  WIDTH_MAIN  SRAM read data.
- sram_dq_oe  out  1  active-high: drive sram_dq_out onto the SRAM data pins.
- sram_ce_n, sram_oe_n, sram_we_n  out  1 each  active-low SRAM strobes.

Behaviour:
- Reset (async, any state):
  - State is IDLE.
  - sram_ce_n, sram_oe_n, sram_we_n = 1; sram_dq_oe = 0.
  - sram_addr, sram_dq_out, main_out = 0.
  - main_en = 0; ready = 1; wait counter = 0.
- States: IDLE, SETUP, ACCESS, RECOVER, HOLD.
- IDLE, request sampled at posedge and accepted only when addr_valid = 1:
  - write_mem = 0 and read_mem = 1: latch addr_in→sram_addr and main_in→sram_dq_out, set op = WRITE, go SETUP.
  - read_mem = 0 and write_mem = 1: latch addr_in, set op = READ, go SETUP.
  - Both strobes low: illegal; ignored, stay IDLE.
  - addr_valid = 0: ignored.
- SETUP (1 cycle):
  - sram_ce_n = 0.
  - READ: sram_oe_n = 0. WRITE: sram_dq_oe = 1, sram_we_n = 1.
  - Load wait counter with WAIT_STATES; go ACCESS.
- ACCESS (WAIT_STATES+1 cycles):
  - ce low; WRITE: we_n = 0, dq_oe = 1; READ: oe_n = 0.
  - Counter decrements each cycle.
  - At counter = 0:
    - READ: capture sram_dq_in→main_out, go HOLD.
    - WRITE: go RECOVER.
- RECOVER (WRITE only, 1 cycle): we_n = 1, ce_n = 0, dq_oe = 1 (data hold); then IDLE.
- HOLD (READ only):
  - ce_n, oe_n = 1; ready = 1; main_en = ~read_mem.
  - Stay while read_mem = 0; go IDLE when read_mem = 1.
  - main_out retains its value until the next read capture.
- ready = 1 only in IDLE and HOLD; 0 in SETUP, ACCESS, RECOVER.
- main_en is 0 in every state except HOLD.
- Latency, counted from the accept edge:
  - READ: ready low for WAIT_STATES+2 cycles; data valid on main_out the cycle ready rises.
  - WRITE: ready low for WAIT_STATES+3 cycles.
- Strobe or addr_valid changes after acceptance are ignored; the transaction always completes.
- A new request is accepted in IDLE only, never in HOLD. Back-to-back reads need one cycle with read_mem high.
- Reset asserted mid-access aborts immediately: we_n rises asynchronously and there is no partial-write guarantee.

Decomposition:
- Shared package jspcpu_pkg holds:
  - State encoding localparams: ST_IDLE = 0, ST_SETUP = 1, ST_ACCESS = 2, ST_RECOVER = 3, ST_HOLD = 4 (3 bits).
  - OP_READ/OP_WRITE constants.
  - Default bus widths of 16 and 8.
- One natural sub-module: wait_counter (4-bit loadable down-counter with zero flag), reused by other wait-stated peripherals.

Test Plan:
- Reset mid-ACCESS of a write (WAIT_STATES = 2, addr 0x1234, data 0xA5) → next sample shows we_n = 1, ce_n = 1, dq_oe = 0, ready = 1, state IDLE.
- Write addr 0xBEEF, data 0x5A, WAIT_STATES = 2 →
  - ready low exactly 5 cycles;
  - we_n low exactly 3 cycles;
  - dq_oe high 5 cycles with sram_dq_out = 0x5A and sram_addr = 0xBEEF throughout.
- Read addr 0x00FF with SRAM model returning 0x3C →
  - ready low 4 cycles, then main_out = 0x3C and main_en = 1;
  - main_en drops the cycle after read_mem returns high.
- Both strobes low with addr_valid = 1 → stays IDLE, all SRAM strobes high, ready = 1. Separately, read_mem low with addr_valid = 0 → ignored.
- WAIT_STATES = 0 read then immediate write (read_mem released one cycle) → read ready low 2 cycles, write ready low 3 cycles, and the write data does not corrupt main_out (still the read value).
- Strobes toggled during ACCESS → latched addr/data unchanged; transaction completes with the originally requested length.
